// File: rtl/halton_seq_pkg.sv
// Shared types and constants for the Halton sequencing controller.
package halton_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

   localparam logic [1:0] BASE_SEL_2    = 2'b00;
   localparam logic [1:0] BASE_SEL_3    = 2'b01;
   localparam logic [1:0] BASE_SEL_7    = 2'b10;
   localparam logic [1:0] BASE_SEL_RSVD = 2'b11;

   // Fraction bits of the 16.16 result format.
   localparam int unsigned FRAC_W = 16;

   function automatic logic base_sel_ok(input logic [1:0] sel);
      return sel != BASE_SEL_RSVD;
   endfunction

endpackage

// File: rtl/halton_seq_ctrl_if.sv
// Generator handshake and output point stream of halton_seq_ctrl.
interface halton_seq_ctrl_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned K_W    = 32
);
   logic              gen_start;
   logic [K_W-1:0]    gen_k;
   logic [1:0]        gen_base0_sel;
   logic [1:0]        gen_base1_sel;
   logic              gen_ready;
   logic              gen_done;
   logic [DATA_W-1:0] gen_result_x;
   logic [DATA_W-1:0] gen_result_y;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_x;
   logic [DATA_W-1:0] out_y;
   logic [K_W-1:0]    out_k;
   logic              out_last;

   modport master (
      output gen_start, gen_k, gen_base0_sel, gen_base1_sel,
      input  gen_ready, gen_done, gen_result_x, gen_result_y,
      output out_valid, out_x, out_y, out_k, out_last,
      input  out_ready
   );

   modport slave (
      input  gen_start, gen_k, gen_base0_sel, gen_base1_sel,
      output gen_ready, gen_done, gen_result_x, gen_result_y,
      input  out_valid, out_x, out_y, out_k, out_last,
      output out_ready
   );
endinterface

// File: rtl/halton_seq_obuf.sv
// Registered valid/ready output buffer of DEPTH (1 or 2) entries; the head
// register drives the stream directly. Push has no backpressure: the writer
// guarantees space.
module halton_seq_obuf #(
   parameter int unsigned W     = 97,
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   count
);
   logic         head_v, tail_v;
   logic [W-1:0] head_d, tail_d;
   logic         pop;

   assign pop       = head_v & out_ready;
   assign out_valid = head_v;
   assign out_data  = head_d;
   assign count     = {1'b0, head_v} + {1'b0, tail_v};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_v <= 1'b0;
         tail_v <= 1'b0;
         head_d <= '0;
         tail_d <= '0;
      end else if (flush) begin
         head_v <= 1'b0;
         tail_v <= 1'b0;
      end else if (pop) begin
         if (tail_v) begin
            head_d <= tail_d;
            tail_v <= push;
            if (push) tail_d <= push_data;
         end else begin
            head_v <= push;
            if (push) head_d <= push_data;
         end
      end else if (!head_v) begin
         head_v <= push;
         if (push) head_d <= push_data;
      end else if (push && DEPTH > 1) begin
         tail_v <= 1'b1;
         tail_d <= push_data;
      end
   end
endmodule

// File: rtl/halton_seq_ctrl.sv
// Run sequencer for the Halton point generator.
// Define HALTON_SEQ_PREFETCH_EN for a 2-entry output buffer with overlapped issue.
module halton_seq_ctrl
   import halton_seq_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned K_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_start,
   input  logic             cfg_abort,
   input  logic [K_W-1:0]   cfg_k_first,
   input  logic [K_W-1:0]   cfg_count,
   input  logic [1:0]       cfg_base0_sel,
   input  logic [1:0]       cfg_base1_sel,
   output logic             busy,
   output logic             seq_done,
   output logic             cfg_err,
   halton_seq_ctrl_if.master bus
);
`ifdef HALTON_SEQ_PREFETCH_EN
   localparam int unsigned OBUF_DEPTH = 2;
`else
   localparam int unsigned OBUF_DEPTH = 1;
`endif
   localparam int unsigned PW = 2 * DATA_W + K_W + 1;

   state_t         state;
   logic [K_W-1:0] iss_left;
   logic           push_v;
   logic [PW-1:0]  push_d;
   logic [PW-1:0]  obuf_data;
   logic [1:0]     obuf_cnt;
   logic           space;
   logic           xfer;

   // An in-flight push still occupies a slot until the buffer registers it.
   assign space = (32'(obuf_cnt) + 32'(push_v)) < OBUF_DEPTH;
   assign xfer  = bus.out_valid & bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= ST_IDLE;
         busy              <= 1'b0;
         seq_done          <= 1'b0;
         cfg_err           <= 1'b0;
         bus.gen_start     <= 1'b0;
         bus.gen_k         <= '0;
         bus.gen_base0_sel <= '0;
         bus.gen_base1_sel <= '0;
         iss_left          <= '0;
         push_v            <= 1'b0;
         push_d            <= '0;
      end else begin
         seq_done      <= 1'b0;
         cfg_err       <= 1'b0;
         bus.gen_start <= 1'b0;
         push_v        <= 1'b0;
         if (cfg_abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (cfg_start) begin
                     if (!base_sel_ok(cfg_base0_sel) || !base_sel_ok(cfg_base1_sel)) begin
                        cfg_err <= 1'b1;
                     end else if (cfg_count == '0) begin
                        seq_done <= 1'b1;
                     end else begin
                        bus.gen_base0_sel <= cfg_base0_sel;
                        bus.gen_base1_sel <= cfg_base1_sel;
                        bus.gen_k         <= cfg_k_first;
                        iss_left          <= cfg_count;
                        busy              <= 1'b1;
                        state             <= ST_ISSUE;
                     end
                  end
               end
               ST_ISSUE: begin
                  if (bus.gen_ready && space) begin
                     bus.gen_start <= 1'b1;
                     state         <= ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  // Done may still be high from the previous point while start is out.
                  if (!bus.gen_start && bus.gen_done) begin
                     push_v    <= 1'b1;
                     push_d    <= {bus.gen_result_x, bus.gen_result_y, bus.gen_k,
                                   iss_left == K_W'(1)};
                     iss_left  <= iss_left - K_W'(1);
                     bus.gen_k <= bus.gen_k + K_W'(1);
                     state     <= (OBUF_DEPTH > 1 && iss_left != K_W'(1)) ? ST_ISSUE : ST_OUT;
                  end
               end
               ST_OUT: begin
                  if (xfer) begin
                     if (bus.out_last) begin
                        seq_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                     end else if (iss_left != '0) begin
                        state <= ST_ISSUE;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   halton_seq_obuf #(
      .W     (PW),
      .DEPTH (OBUF_DEPTH)
   ) u_obuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (cfg_abort),
      .push      (push_v),
      .push_data (push_d),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (obuf_data),
      .count     (obuf_cnt)
   );

   assign {bus.out_x, bus.out_y, bus.out_k, bus.out_last} = obuf_data;

endmodule
